// File: rtl/serial_bit_source.sv
// serial_bit_source
// -----------------
// Parallel-to-serial front end for the serial sequence detectors. A WIDTH-bit
// word is accepted over a valid/ready handshake and then presented one bit per
// clock on x_out, with framing strobes for downstream alignment. A programmable
// idle gap separates frames.
//
// Optional feature (compile-time macro): SER_PARITY_EN
//   Defined   : an even-parity bit (XOR of all data bits) follows the data bits,
//               making each frame WIDTH+1 bits long; frame_done marks the parity bit.
//   Undefined : frame is WIDTH data bits, no parity logic.
//
// Parameters:
//   WIDTH      data bits per frame (2..32)
//   GAP_CYCLES idle cycles after each frame before data_ready reasserts (0..15)
//   MSB_FIRST  1 = bit WIDTH-1 goes out first, 0 = bit 0 first
//
// Ports:
//   CLK        system clock, rising edge
//   Reset      synchronous active-high reset
//   data_in    parallel word to serialise
//   data_valid data_in is valid
//   data_ready block accepts a word this cycle
//   x_out      serial bit stream (0 whenever bit_valid is low)
//   bit_valid  x_out carries a frame bit this cycle
//   frame_done one-cycle pulse with the final bit of a frame
//   busy       high while shifting or in the gap
module serial_bit_source #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e          state_q;
  logic [FLEN-1:0] sr_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q;
  logic            ready_q;
  logic            x_q;
  logic            bv_q;
  logic            fd_q;
  logic            busy_q;

  // Frame image built from the incoming word; parity sits at the tail end of
  // the shift order so it always leaves last.
  logic [FLEN-1:0] frame_d;
`ifdef SER_PARITY_EN
  logic            par_d;
`endif

  always_comb begin
`ifdef SER_PARITY_EN
    par_d = ^data_in;
    if (MSB_FIRST != 0) frame_d = {data_in, par_d};
    else                frame_d = {par_d, data_in};
`else
    frame_d = data_in;
`endif
  end

  // Head bit goes onto x_out now; the remainder is parked in the shift register.
  logic            load_head_d;
  logic [FLEN-1:0] load_rest_d;
  logic            sr_head_d;
  logic [FLEN-1:0] sr_rest_d;

  always_comb begin
    if (MSB_FIRST != 0) begin
      load_head_d = frame_d[FLEN-1];
      load_rest_d = frame_d << 1;
      sr_head_d   = sr_q[FLEN-1];
      sr_rest_d   = sr_q << 1;
    end else begin
      load_head_d = frame_d[0];
      load_rest_d = frame_d >> 1;
      sr_head_d   = sr_q[0];
      sr_rest_d   = sr_q >> 1;
    end
  end

  // cnt_q counts bits still to present after the one currently on x_out.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      x_q     <= 1'b0;
      bv_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            sr_q    <= load_rest_d;
            cnt_q   <= CW'(FLEN - 1);
            x_q     <= load_head_d;
            bv_q    <= 1'b1;
            fd_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            x_q  <= 1'b0;
            bv_q <= 1'b0;
            fd_q <= 1'b0;
            sr_q <= '0;
            if (GAP_CYCLES > 0) begin
              gap_q   <= GW'(GAP_CYCLES - 1);
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= GAP;
            end else begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            x_q   <= sr_head_d;
            sr_q  <= sr_rest_d;
            cnt_q <= cnt_q - CW'(1);
            fd_q  <= (cnt_q == CW'(1));
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_ready = ready_q;
  assign x_out      = x_q;
  assign bit_valid  = bv_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Testbench for serial_bit_source: two instances (MSB-first with a one-cycle
// gap, LSB-first with no gap) checked every cycle against a queue-based
// reference that lists the expected output of each upcoming cycle.
module tb_serial_bit_source;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif
  localparam int GAP_A = 1;
  localparam int GAP_B = 0;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] din_a = '0, din_b = '0;
  logic         dv_a = 1'b0, dv_b = 1'b0;
  logic         rdy_a, x_a, bv_a, fd_a, busy_a;
  logic         rdy_b, x_b, bv_b, fd_b, busy_b;

  always #5 CLK = ~CLK;

  serial_bit_source #(.WIDTH(W), .GAP_CYCLES(GAP_A), .MSB_FIRST(1)) dut_a (
    .CLK(CLK), .Reset(Reset), .data_in(din_a), .data_valid(dv_a),
    .data_ready(rdy_a), .x_out(x_a), .bit_valid(bv_a), .frame_done(fd_a), .busy(busy_a)
  );

  serial_bit_source #(.WIDTH(W), .GAP_CYCLES(GAP_B), .MSB_FIRST(0)) dut_b (
    .CLK(CLK), .Reset(Reset), .data_in(din_b), .data_valid(dv_b),
    .data_ready(rdy_b), .x_out(x_b), .bit_valid(bv_b), .frame_done(fd_b), .busy(busy_b)
  );

  typedef struct packed {
    logic x;
    logic bv;
    logic fd;
    logic busy;
  } ent_t;

  localparam ent_t IDLE_ENT = '{x: 1'b0, bv: 1'b0, fd: 1'b0, busy: 1'b0};
  localparam ent_t GAP_ENT  = '{x: 1'b0, bv: 1'b0, fd: 1'b0, busy: 1'b1};

  ent_t qa[$];
  ent_t qb[$];
  int   passes = 0;
  int   total  = 0;

  // Frame bit i in transmission order: data bits in the chosen order, then parity.
  function automatic ent_t frame_entry(input logic [W-1:0] d, input int i, input bit msb);
    ent_t e;
    e.busy = 1'b1;
    e.bv   = 1'b1;
    e.fd   = (i == FLEN - 1);
    if (i < W) e.x = msb ? d[W-1-i] : d[i];
    else       e.x = ^d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock: update the reference with the inputs seen at the edge,
  // then compare every output 1 time unit later.
  task automatic step();
    ent_t ea, eb;
    @(posedge CLK);
    if (Reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0) void'(qa.pop_front());
      else if (dv_a) begin
        for (int i = 0; i < FLEN; i++) qa.push_back(frame_entry(din_a, i, 1'b1));
        for (int g = 0; g < GAP_A; g++) qa.push_back(GAP_ENT);
      end
      if (qb.size() > 0) void'(qb.pop_front());
      else if (dv_b) begin
        for (int i = 0; i < FLEN; i++) qb.push_back(frame_entry(din_b, i, 1'b0));
        for (int g = 0; g < GAP_B; g++) qb.push_back(GAP_ENT);
      end
    end
    #1;
    ea = (qa.size() > 0) ? qa[0] : IDLE_ENT;
    eb = (qb.size() > 0) ? qb[0] : IDLE_ENT;
    chk("a_ready", rdy_a, qa.size() == 0);
    chk("a_x", x_a, ea.x);
    chk("a_bit_valid", bv_a, ea.bv);
    chk("a_frame_done", fd_a, ea.fd);
    chk("a_busy", busy_a, ea.busy);
    chk("b_ready", rdy_b, qb.size() == 0);
    chk("b_x", x_b, eb.x);
    chk("b_bit_valid", bv_b, eb.bv);
    chk("b_frame_done", fd_b, eb.fd);
    chk("b_busy", busy_b, eb.busy);
  endtask

  logic [W-1:0] cap_a, cap_b;

  initial begin
    // Reset 3 cycles, then idle 5 cycles.
    for (int i = 0; i < 3; i++) step();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // 0xB4 into both instances; collect the 8 data bits as they appear.
    din_a = 8'hB4; din_b = 8'hB4; dv_a = 1'b1; dv_b = 1'b1;
    cap_a = '0; cap_b = '0;
    for (int i = 0; i < W; i++) begin
      step();
      dv_a = 1'b0; dv_b = 1'b0;
      cap_a = {cap_a[W-2:0], x_a};
      cap_b[i] = x_b;
    end
    total++;
    assert (cap_a === 8'hB4) begin passes++; end
    else $error("FAIL a_seq_B4 observed=%h expected=%h", cap_a, 8'hB4);
    total++;
    assert (cap_b === 8'hB4) begin passes++; end
    else $error("FAIL b_seq_B4 observed=%h expected=%h", cap_b, 8'hB4);
    for (int i = 0; i < 4; i++) step();

    // Back-to-back: valid held high, 0xFF then 0x00.
    din_a = 8'hFF; din_b = 8'hFF; dv_a = 1'b1; dv_b = 1'b1;
    for (int i = 0; i < 4; i++) step();
    din_a = 8'h00; din_b = 8'h00;
    for (int i = 0; i < 2 * (FLEN + 2); i++) step();
    dv_a = 1'b0; dv_b = 1'b0;
    for (int i = 0; i < FLEN + 3; i++) step();

    // 0xAA aborted by reset during its 4th bit, then 0x81.
    din_a = 8'hAA; din_b = 8'hAA; dv_a = 1'b1; dv_b = 1'b1;
    step();
    dv_a = 1'b0; dv_b = 1'b0;
    for (int i = 0; i < 3; i++) step();
    Reset = 1'b1; dv_a = 1'b1; dv_b = 1'b1;
    step();
    Reset = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
    step();
    din_a = 8'h81; din_b = 8'h81; dv_a = 1'b1; dv_b = 1'b1;
    step();
    dv_a = 1'b0; dv_b = 1'b0;
    for (int i = 0; i < FLEN + 3; i++) step();

    // Parity corner words (also plain frames when parity is off).
    din_a = 8'h07; din_b = 8'h03; dv_a = 1'b1; dv_b = 1'b1;
    step();
    dv_a = 1'b0; dv_b = 1'b0;
    for (int i = 0; i < FLEN + 3; i++) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      din_a = W'($urandom); din_b = W'($urandom);
      dv_a  = ($urandom_range(0, 2) != 0);
      dv_b  = ($urandom_range(0, 2) != 0);
      Reset = ($urandom_range(0, 49) == 0);
      step();
    end
    Reset = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
    for (int i = 0; i < FLEN + 3; i++) step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
